// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI response arbiter: FSM encoding and owner index sizing.
package spi_arb_pkg;
    localparam int N_REQ_MAX = 8;
    localparam int OWNER_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;
endpackage

// File: rtl/spi_resp_arb_if.sv
// Arbiter <-> protocol wrapper response channel (request/grant, muxed byte, end of transaction).
interface spi_resp_arb_if;
    logic       pw_req;
    logic       pw_gnt;
    logic [7:0] pw_rdata;
    logic       pw_rstb;
    logic       pw_end;

    modport master (output pw_req, output pw_rdata, output pw_rstb,
                    input  pw_gnt, input  pw_end);
    modport slave  (input  pw_req, input  pw_rdata, input  pw_rstb,
                    output pw_gnt, output pw_end);
endinterface

// File: rtl/spi_arb_pick.sv
// Rotating-mask priority encoder: lowest set request at or above the pointer, else lowest overall.
module spi_arb_pick
    import spi_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [OWNER_W-1:0] pointer,
    output logic [N_REQ-1:0]   winner,
    output logic [OWNER_W-1:0] index
);
    logic [N_REQ-1:0] upper;
    logic [N_REQ-1:0] scan;

    // Requests below the pointer only win when nothing at or above it is asking.
    always_comb begin
        upper = '0;
        for (int k = 0; k < N_REQ; k++) begin
            upper[k] = req[k] && (OWNER_W'(k) >= pointer);
        end
        scan   = (|upper) ? upper : req;
        winner = '0;
        index  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (scan[k]) begin
                winner    = '0;
                winner[k] = 1'b1;
                index     = OWNER_W'(k);
            end
        end
    end
endmodule

// File: rtl/spi_resp_arb.sv
// Arbitrates N_REQ response sources onto one SPI protocol wrapper channel.
// Define SPI_RESP_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module spi_resp_arb
    import spi_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [8*N_REQ-1:0]   rdata_i,
    input  logic [N_REQ-1:0]     rstb_i,
    output logic [N_REQ-1:0]     gnt_o,
    output logic [OWNER_W-1:0]   owner_o,
    spi_resp_arb_if.master       pw
);
    arb_state_t          state;
    logic [N_REQ-1:0]    owner;
    logic [OWNER_W-1:0]  owner_idx;
    logic                pw_req_q;
    logic [OWNER_W-1:0]  pointer;
    logic [N_REQ-1:0]    win_oh;
    logic [OWNER_W-1:0]  win_idx;
    logic                owner_req;
    logic [7:0]          rdata_mux;

`ifndef SPI_RESP_ARB_RR_EN
    assign pointer = '0;
`endif

    spi_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (req_i),
        .pointer (pointer),
        .winner  (win_oh),
        .index   (win_idx)
    );

    assign owner_req = |(req_i & owner);

    // pw_req stays high through BUSY since the owner still holds the channel until pw_end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            owner_idx <= '0;
            pw_req_q  <= 1'b0;
`ifdef SPI_RESP_ARB_RR_EN
            pointer   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        owner     <= win_oh;
                        owner_idx <= win_idx;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (!owner_req) begin
                        owner     <= '0;
                        owner_idx <= '0;
                        pw_req_q  <= 1'b0;
                        state     <= IDLE;
                    end else if (pw.pw_gnt) begin
                        pw_req_q  <= 1'b1;
                        state     <= BUSY;
                    end else begin
                        pw_req_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (pw.pw_end) begin
`ifdef SPI_RESP_ARB_RR_EN
                        pointer   <= (owner_idx == OWNER_W'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
`endif
                        owner     <= '0;
                        owner_idx <= '0;
                        pw_req_q  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    owner     <= '0;
                    owner_idx <= '0;
                    pw_req_q  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // An empty owner vector selects nothing, so the muxed byte reads zero in IDLE.
    always_comb begin
        rdata_mux = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner[k]) begin
                rdata_mux = rdata_mux | rdata_i[8*k +: 8];
            end
        end
    end

    assign pw.pw_req   = pw_req_q;
    assign pw.pw_rdata = rdata_mux;
    assign pw.pw_rstb  = |(rstb_i & owner);
    assign gnt_o       = owner & {N_REQ{pw.pw_gnt}};
    assign owner_o     = owner_idx;
endmodule

// File: tb/tb_spi_resp_arb.sv
// Directed scoreboard bench for spi_resp_arb; expectations follow SPI_RESP_ARB_RR_EN when defined.
module tb_spi_resp_arb;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [31:0] rdata_i;
    logic [3:0]  rstb_i;
    logic [3:0]  gnt_o;
    logic [2:0]  owner_o;

    spi_resp_arb_if pw_bus ();

    spi_resp_arb #(.N_REQ(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .rdata_i (rdata_i),
        .rstb_i  (rstb_i),
        .gnt_o   (gnt_o),
        .owner_o (owner_o),
        .pw      (pw_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int ptr_m   = 0;
    int cur_owner = 0;
    int exp_q[$];
    logic [31:0] rdata_pat = 32'h4D3C_A51E;
    logic [3:0]  rstb_pat  = 4'b0110;
    logic [3:0]  one_hot;

    function automatic int model_pick(logic [3:0] req, int ptr);
`ifdef SPI_RESP_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            if (req[(ptr + i) % 4]) return (ptr + i) % 4;
        end
`else
        for (int i = 0; i < 4; i++) begin
            if (req[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(logic [3:0] req);
        req_i = req;
        exp_q.push_back(model_pick(req, ptr_m));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req_i = '0;
        pw_bus.pw_gnt = 1'b0;
        pw_bus.pw_end = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        exp_q.delete();
    endtask

    task automatic grantOne();
        int exp;
        for (int i = 0; i < 6 && !pw_bus.pw_req; i++) tick();
        checkOutput("pw_req_wait", 32'(pw_bus.pw_req), 32'd1);
        pw_bus.pw_gnt = 1'b1;
        #1;
        exp = exp_q.pop_front();
        cur_owner = exp;
        one_hot = 4'b0001 << exp;
        checkOutput("owner", 32'(owner_o), 32'(exp));
        checkOutput("gnt_o", 32'(gnt_o), 32'(one_hot));
        checkOutput("pw_rdata", 32'(pw_bus.pw_rdata), (rdata_pat >> (8 * exp)) & 32'hFF);
        checkOutput("pw_rstb", 32'(pw_bus.pw_rstb), 32'(rstb_pat[exp]));
    endtask

    task automatic releaseOne();
        pw_bus.pw_end = 1'b1;
        tick();
        pw_bus.pw_end = 1'b0;
        pw_bus.pw_gnt = 1'b0;
`ifdef SPI_RESP_ARB_RR_EN
        ptr_m = (cur_owner + 1) % 4;
`endif
        #1;
        checkOutput("rel_owner", 32'(owner_o), 32'd0);
        checkOutput("rel_gnt", 32'(gnt_o), 32'd0);
    endtask

    task automatic serveOne();
        grantOne();
        tick();
        releaseOne();
    endtask

    initial begin
        rdata_i = rdata_pat;
        rstb_i  = rstb_pat;
        doReset();
        checkOutput("rst_pw_req", 32'(pw_bus.pw_req), 32'd0);
        checkOutput("rst_gnt", 32'(gnt_o), 32'd0);
        checkOutput("rst_owner", 32'(owner_o), 32'd0);
        checkOutput("rst_rdata", 32'(pw_bus.pw_rdata), 32'd0);
        checkOutput("rst_rstb", 32'(pw_bus.pw_rstb), 32'd0);

        $display("[TB] single requester");
        applyStimulus(4'b0010);
        tick();
        checkOutput("lat1_pw_req", 32'(pw_bus.pw_req), 32'd0);
        tick();
        checkOutput("lat2_pw_req", 32'(pw_bus.pw_req), 32'd1);
        serveOne();
        req_i = '0;
        tick();

        $display("[TB] held 1111");
        doReset();
        for (int t = 0; t < 5; t++) begin
            applyStimulus(4'b1111);
            serveOne();
        end
        req_i = '0;
        tick();

        $display("[TB] held 1010");
        for (int t = 0; t < 3; t++) begin
            applyStimulus(4'b1010);
            serveOne();
        end
        req_i = '0;
        tick();

        $display("[TB] withdrawal");
        req_i = 4'b0100;
        tick();
        tick();
        checkOutput("wd_pw_req", 32'(pw_bus.pw_req), 32'd1);
        checkOutput("wd_gnt", 32'(gnt_o), 32'd0);
        pw_bus.pw_end = 1'b1;
        tick();
        pw_bus.pw_end = 1'b0;
        checkOutput("armed_end_pw_req", 32'(pw_bus.pw_req), 32'd1);
        checkOutput("armed_end_owner", 32'(owner_o), 32'd2);
        req_i = '0;
        tick();
        checkOutput("wd_drop_pw_req", 32'(pw_bus.pw_req), 32'd0);
        checkOutput("wd_drop_owner", 32'(owner_o), 32'd0);
        checkOutput("wd_drop_gnt", 32'(gnt_o), 32'd0);
        applyStimulus(4'b1111);
        serveOne();
        req_i = '0;
        tick();

        $display("[TB] no preemption");
        applyStimulus(4'b0100);
        grantOne();
        tick();
        req_i = 4'b0101;
        repeat (3) tick();
        checkOutput("np_owner", 32'(owner_o), 32'd2);
        checkOutput("np_gnt", 32'(gnt_o), 32'h4);
        req_i = 4'b0001;
        releaseOne();
        applyStimulus(4'b0001);
        serveOne();
        req_i = '0;
        tick();

        $display("[TB] reset mid-busy");
        applyStimulus(4'b0010);
        grantOne();
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_gnt", 32'(gnt_o), 32'd0);
        checkOutput("mid_rst_pw_req", 32'(pw_bus.pw_req), 32'd0);
        checkOutput("mid_rst_owner", 32'(owner_o), 32'd0);
        checkOutput("mid_rst_rdata", 32'(pw_bus.pw_rdata), 32'd0);
        checkOutput("mid_rst_rstb", 32'(pw_bus.pw_rstb), 32'd0);
        rst_n = 1'b1;
        pw_bus.pw_gnt = 1'b0;
        ptr_m = 0;
        exp_q.delete();
        applyStimulus(4'b1001);
        serveOne();
        req_i = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
